// File: rtl/pong_pkg.sv
// Shared encodings and default sizing for the Pong match controller.
package pong_pkg;

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } match_state_e;

  localparam int unsigned WIN_SCORE_DEF   = 10;
  localparam int unsigned SERVE_TICKS_DEF = 24;
  localparam int unsigned SCORE_W_DEF     = 4;
  localparam int unsigned CNT_W_DEF       = 6;

  // Serve direction points at the player who conceded the last point.
  localparam logic DIR_P1 = 1'b0;
  localparam logic DIR_P2 = 1'b1;

endpackage

// File: rtl/serve_timer.sv
// Loadable down-counter that holds the ball centred before each serve.
module serve_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             hold,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Zero is terminal; load takes priority over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && !hold && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer: game FSM, scores, serve delay and win decision.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
  parameter int unsigned SERVE_TICKS = SERVE_TICKS_DEF,
  parameter int unsigned SCORE_W     = SCORE_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               pause,
  input  logic               goal_left,
  input  logic               goal_right,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               ball_hold,
  output logic               ball_center,
  output logic               serve_dir,
  output logic               p1_win,
  output logic               p2_win
);

  match_state_e       state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [SCORE_W-1:0] p1_inc, p2_inc;
  logic               hold_q, hold_d;
  logic               center_q, center_d;
  logic               dir_q, dir_d;
  logic               p1_win_q, p1_win_d;
  logic               p2_win_q, p2_win_d;
  logic               timer_load;
  logic               timer_hold;
  logic               timer_done;

  // Countdown only runs while serving an enabled, unpaused match.
  assign timer_hold = (state_q != QGAME_1) || pause || !start;

  serve_timer #(
    .CNT_W (CNT_W)
  ) u_serve_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (CNT_W'(SERVE_TICKS)),
    .tick     (tick),
    .hold     (timer_hold),
    .done     (timer_done)
  );

  assign p1_inc = p1_q + SCORE_W'(1);
  assign p2_inc = p2_q + SCORE_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= QI;
      p1_q     <= '0;
      p2_q     <= '0;
      hold_q   <= 1'b1;
      center_q <= 1'b0;
      dir_q    <= DIR_P1;
      p1_win_q <= 1'b0;
      p2_win_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      hold_q   <= hold_d;
      center_q <= center_d;
      dir_q    <= dir_d;
      p1_win_q <= p1_win_d;
      p2_win_q <= p2_win_d;
    end
  end

  // Next-state, score and control decode.
  always_comb begin
    state_d    = state_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    dir_d      = dir_q;
    p1_win_d   = p1_win_q;
    p2_win_d   = p2_win_q;
    center_d   = 1'b0;
    timer_load = 1'b0;

    case (state_q)
      QI: begin
        if (start) begin
          state_d    = QGAME_1;
          p1_d       = '0;
          p2_d       = '0;
          p1_win_d   = 1'b0;
          p2_win_d   = 1'b0;
          dir_d      = DIR_P1;
          center_d   = 1'b1;
          timer_load = 1'b1;
        end
      end
      QGAME_1: begin
        if (!start) begin
          state_d = QI;
        end else if (tick && !pause && timer_done) begin
          state_d = QGAME_2;
        end
      end
      QGAME_2: begin
        if (!start) begin
          state_d = QI;
        end else if (goal_left && goal_right) begin
          // Simultaneous exits are ambiguous: replay the point.
          state_d    = QGAME_1;
          center_d   = 1'b1;
          timer_load = 1'b1;
        end else if (goal_left) begin
          p2_d  = p2_inc;
          dir_d = DIR_P1;
          if (p2_inc == SCORE_W'(WIN_SCORE)) begin
            state_d  = QDONE;
            p2_win_d = 1'b1;
          end else begin
            state_d    = QGAME_1;
            center_d   = 1'b1;
            timer_load = 1'b1;
          end
        end else if (goal_right) begin
          p1_d  = p1_inc;
          dir_d = DIR_P2;
          if (p1_inc == SCORE_W'(WIN_SCORE)) begin
            state_d  = QDONE;
            p1_win_d = 1'b1;
          end else begin
            state_d    = QGAME_1;
            center_d   = 1'b1;
            timer_load = 1'b1;
          end
        end
      end
      QDONE: begin
        if (!start) begin
          state_d = QI;
        end
      end
      default: begin
        state_d = QI;
      end
    endcase

    // Ball moves only in an unpaused rally.
    hold_d = !((state_d == QGAME_2) && !pause);
  end

  assign state       = state_q;
  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign ball_hold   = hold_q;
  assign ball_center = center_q;
  assign serve_dir   = dir_q;
  assign p1_win      = p1_win_q;
  assign p2_win      = p2_win_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with a cycle-level behavioural match model.
module tb_pong_match_ctrl;

  localparam int WIN   = 10;
  localparam int SERVE = 24;

  logic       clk = 1'b0;
  logic       reset, tick, start, pause, goal_left, goal_right;
  logic [1:0] state;
  logic [3:0] p1_score, p2_score;
  logic       ball_hold, ball_center, serve_dir, p1_win, p2_win;

  int n_cmp = 0;
  int n_bad = 0;

  pong_match_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .pause       (pause),
    .goal_left   (goal_left),
    .goal_right  (goal_right),
    .state       (state),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .ball_hold   (ball_hold),
    .ball_center (ball_center),
    .serve_dir   (serve_dir),
    .p1_win      (p1_win),
    .p2_win      (p2_win)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: phase 0 idle, 1 serving, 2 rally, 3 finished.
  int phase, pts1, pts2, served;
  bit exp_hold, exp_center, exp_dir, won1, won2;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      phase = 0; pts1 = 0; pts2 = 0; served = 0;
      exp_hold = 1; exp_center = 0; exp_dir = 0; won1 = 0; won2 = 0;
      model_valid = 1'b1;
    end else begin
      exp_center = 0;
      if (phase == 0) begin
        if (start) begin
          phase = 1; pts1 = 0; pts2 = 0; won1 = 0; won2 = 0;
          exp_dir = 0; served = 0; exp_center = 1;
        end
      end else if (phase == 1) begin
        if (!start) phase = 0;
        else if (tick && !pause) begin
          served++;
          if (served > SERVE) phase = 2;
        end
      end else if (phase == 2) begin
        if (!start) phase = 0;
        else if (goal_left && goal_right) begin
          phase = 1; served = 0; exp_center = 1;
        end else if (goal_left || goal_right) begin
          if (goal_left) begin pts2++; exp_dir = 0; end
          else           begin pts1++; exp_dir = 1; end
          if (pts1 == WIN) begin phase = 3; won1 = 1; end
          else if (pts2 == WIN) begin phase = 3; won2 = 1; end
          else begin phase = 1; served = 0; exp_center = 1; end
        end
      end else begin
        if (!start) phase = 0;
      end
      exp_hold = !(phase == 2 && !pause);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_state",  int'(state),       phase);
      chk("m_p1",     int'(p1_score),    pts1);
      chk("m_p2",     int'(p2_score),    pts2);
      chk("m_hold",   int'(ball_hold),   int'(exp_hold));
      chk("m_center", int'(ball_center), int'(exp_center));
      chk("m_dir",    int'(serve_dir),   int'(exp_dir));
      chk("m_p1win",  int'(p1_win),      int'(won1));
      chk("m_p2win",  int'(p2_win),      int'(won2));
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic goal(input logic l, input logic r);
    goal_left  = l;
    goal_right = r;
    @(negedge clk);
    goal_left  = 1'b0;
    goal_right = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1; tick = 0; start = 0; pause = 0; goal_left = 0; goal_right = 0;
    repeat (2) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_hold", int'(ball_hold), 1);
    chk("rst_p1", int'(p1_score), 0);
    reset = 0;
    @(negedge clk);
    goal(1'b1, 1'b0);
    tick_n(2);
    chk("idle_goal_ignored", int'(p2_score), 0);

    start = 1;
    @(negedge clk);
    chk("start_state", int'(state), 1);
    chk("start_center", int'(ball_center), 1);
    chk("start_hold", int'(ball_hold), 1);
    @(negedge clk);
    chk("center_once", int'(ball_center), 0);
    tick_n(24);
    chk("serve_24", int'(state), 1);
    tick_n(1);
    chk("serve_25", int'(state), 2);
    chk("rally_hold", int'(ball_hold), 0);

    goal(1'b0, 1'b1);
    chk("gr_p1", int'(p1_score), 1);
    chk("gr_dir", int'(serve_dir), 1);
    chk("gr_state", int'(state), 1);
    chk("gr_center", int'(ball_center), 1);
    tick_n(24);
    chk("reload_24", int'(state), 1);
    tick_n(1);
    chk("reload_25", int'(state), 2);

    for (int i = 0; i < 10; i++) begin
      goal(1'b1, 1'b0);
      if (i < 9) begin
        chk("gl_serve", int'(state), 1);
        tick_n(25);
      end
    end
    chk("win_p2", int'(p2_score), 10);
    chk("win_state", int'(state), 3);
    chk("win_flag", int'(p2_win), 1);
    chk("win_p1flag", int'(p1_win), 0);
    tick_n(2);
    goal(1'b1, 1'b0);
    chk("done_frozen", int'(p2_score), 10);
    start = 0;
    @(negedge clk);
    chk("done_idle", int'(state), 0);
    chk("done_keep", int'(p2_score), 10);
    start = 1;
    @(negedge clk);
    chk("restart_p1", int'(p1_score), 0);
    chk("restart_p2", int'(p2_score), 0);
    chk("restart_win", int'(p2_win), 0);

    tick_n(25);
    goal(1'b0, 1'b1);
    tick_n(25);
    goal(1'b1, 1'b1);
    chk("dbl_p1", int'(p1_score), 1);
    chk("dbl_p2", int'(p2_score), 0);
    chk("dbl_dir", int'(serve_dir), 1);
    chk("dbl_state", int'(state), 1);

    tick_n(5);
    pause = 1;
    tick_n(10);
    chk("pause_serve", int'(state), 1);
    pause = 0;
    tick_n(19);
    chk("pause_19", int'(state), 1);
    tick_n(1);
    chk("pause_20", int'(state), 2);
    pause = 1;
    @(negedge clk);
    chk("pause_hold", int'(ball_hold), 1);
    goal(1'b1, 1'b0);
    chk("pause_goal", int'(p2_score), 1);
    pause = 0;

    tick_n(25); goal(1'b0, 1'b1);
    tick_n(25); goal(1'b0, 1'b1);
    tick_n(25); goal(1'b1, 1'b0);
    tick_n(25);
    chk("abort_pre", int'(state), 2);
    start = 0;
    @(negedge clk);
    chk("abort_state", int'(state), 0);
    chk("abort_p1", int'(p1_score), 3);
    chk("abort_p2", int'(p2_score), 2);
    chk("abort_hold", int'(ball_hold), 1);

    start = 1;
    @(negedge clk);
    tick_n(25);
    goal(1'b0, 1'b1);
    tick_n(25);
    reset = 1;
    @(negedge clk);
    chk("rr_state", int'(state), 0);
    chk("rr_p1", int'(p1_score), 0);
    chk("rr_hold", int'(ball_hold), 1);
    chk("rr_dir", int'(serve_dir), 0);
    chk("rr_center", int'(ball_center), 0);
    reset = 0;
    start = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match-level sequencer for the Pong game. It owns the game state machine, both player scores, the serve delay and the win decision. The ball engine and paddle logic are slaved to it through hold, re-centre and serve-direction controls. It sits between the switch/button inputs and the ball state machine, and it also drives the score SSD digits and the state LEDs.

Parameters:
WIN_SCORE, 10, points needed to win; score that forces QDONE.
SERVE_TICKS, 24, game ticks the ball is held centred before each serve (about 2 s at the DIV_CLK[21] tick rate).
SCORE_W, 4, score width; must hold WIN_SCORE.
CNT_W, 6, serve counter width; must hold SERVE_TICKS.

Ports:
clk  in  1  system clock (the DIV_CLK[1] domain).
reset  in  1  synchronous, active-high.
tick  in  1  single-cycle game-tick enable, derived from the DIV_CLK[21] rising edge.
start  in  1  level; high = match enabled (Sw1).
pause  in  1  level; freezes play and the serve countdown.
goal_left  in  1  1-cycle pulse: ball exited the left edge, P2 scores.
goal_right  in  1  1-cycle pulse: ball exited the right edge, P1 scores.
state  out  2  QI=00, QGAME_1=01 (serve), QGAME_2=10 (rally), QDONE=11.
p1_score  out  SCORE_W  player 1 score.
p2_score  out  SCORE_W  player 2 score.
ball_hold  out  1  1 = ball engine frozen.
ball_center  out  1  1-cycle pulse: ball engine reloads its centre position.
serve_dir  out  1  0 = serve toward P1 (left), 1 = serve toward P2 (right).
p1_win  out  1  sticky in QDONE.
p2_win  out  1  sticky in QDONE.

Behaviour:
- All outputs are registered. A response is visible on the clk edge after the triggering input is sampled.
- Reset values: state=QI, both scores=0, ball_hold=1, ball_center=0, serve_dir=0, p1_win=p2_win=0, serve counter=0.
- QI:
  - ball_hold=1.
  - When start=1: go to QGAME_1, clear scores and win flags, load counter=SERVE_TICKS, pulse ball_center, set serve_dir=0.
- QGAME_1 (serve):
  - ball_hold=1.
  - On tick with pause=0: counter decrements.
  - On tick with pause=0 and counter==0: go to QGAME_2, ball_hold falls on the same edge.
- QGAME_2 (rally):
  - ball_hold=pause.
  - goal_left: p2_score+1, serve_dir=0 (toward the conceding player).
  - goal_right: p1_score+1, serve_dir=1.
  - After a goal: if the new score == WIN_SCORE, go to QDONE and set the matching win flag. Otherwise go to QGAME_1, reload the counter and pulse ball_center.
  - goal_left and goal_right in the same cycle: no score change, serve_dir unchanged, go to QGAME_1 with ball_center pulse (replay the point).
  - Goals while pause=1 are still counted; pause only gates ball motion.
- QDONE:
  - ball_hold=1; scores and win flag frozen.
  - When start=0: go to QI. Scores stay displayed until the next start.
- start=0 in QGAME_1 or QGAME_2 aborts the match: go to QI on the next edge, scores retained, ball_hold=1.
- Goal pulses outside QGAME_2 are ignored. tick is ignored outside QGAME_1.
- Scores never exceed WIN_SCORE and there is no wrap.
- The counter never underflows: 0 is the terminal value.
- reset has priority over every input, in every state.

Decomposition:
- Package pong_pkg holds: state encodings QI/QGAME_1/QGAME_2/QDONE, WIN_SCORE default, serve_dir encodings DIR_P1/DIR_P2.
- Sub-module serve_timer: loadable down-counter with ports load, load_val, tick, hold and done (done = count==0). It is instantiated once.
- The FSM, scores and win logic stay in pong_match_ctrl.

Test Plan:
- Reset, then start=1 one cycle later → state=01, ball_center pulses once, ball_hold=1. With SERVE_TICKS=24, state=10 one edge after the 25th tick.
- In QGAME_2, one goal_right pulse → p1_score=1, serve_dir=1, state=01, ball_center pulses, counter reloaded to 24.
- Ten goal_left pulses, each issued in QGAME_2 → p2_score=10, state=11, p2_win=1. Then start=0 → state=00 with p2_score still 10. Then start=1 → scores 0, p2_win=0.
- goal_left and goal_right in the same cycle → scores unchanged, serve_dir unchanged, state=01.
- pause=1 in QGAME_1 for 10 ticks → counter holds. pause=1 in QGAME_2 → ball_hold=1, and a goal during pause still scores.
- start dropped mid-rally at 3–2 → state=00 next edge, scores stay 3/2. Reset asserted in QGAME_2 → all outputs return to their reset values on the next edge.
